// File: rtl/chunked_subtractor_seq_if.sv
// Handshake bundle for chunked_subtractor_seq: operand channel in, result channel out.
// The ovf wire only exists when SUB_OVERFLOW_EN is defined.
interface chunked_subtractor_seq_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] diff;
    logic             bout;
`ifdef SUB_OVERFLOW_EN
    logic             ovf;
`endif

    // Producer of operands / consumer of results
    modport master (
        output in_valid, a, b, bin, out_ready,
        input  in_ready, out_valid, diff, bout
`ifdef SUB_OVERFLOW_EN
        , input ovf
`endif
    );

    // The subtractor itself
    modport slave (
        input  in_valid, a, b, bin, out_ready,
        output in_ready, out_valid, diff, bout
`ifdef SUB_OVERFLOW_EN
        , output ovf
`endif
    );
endinterface

// File: rtl/chunked_subtractor_seq.sv
// chunked_subtractor_seq: multi-cycle wide subtractor, diff = a - b - bin.
// One CHUNK-bit digit per cycle, LSB first, digit sum a + ~b + ~borrow built
// with carry lookahead; the borrow is chained across cycles in a register.
// Optional feature macro: SUB_OVERFLOW_EN adds a registered signed-overflow flag (ovf).
module chunked_subtractor_seq #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input logic                   clk,
    input logic                   rst,
    chunked_subtractor_seq_if.slave bus
);
    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam int MSB    = WIDTH - 1;

    generate
        if ((CHUNK < 1) || (WIDTH % CHUNK != 0) || (NCHUNK < 1)) begin : g_bad_cfg
            $error("chunked_subtractor_seq: WIDTH must be a non-zero multiple of CHUNK");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t             state;
    state_t             next_state;
    logic               can_accept;
    logic               result_valid;
    logic               accept;
    logic               last_digit;

    logic [WIDTH-1:0]   a_reg;
    logic [WIDTH-1:0]   b_reg;
    logic [WIDTH-1:0]   diff_reg;
    logic               borrow_reg;
    logic               bout_reg;
    logic [IDX_W-1:0]   idx;

    logic [CHUNK-1:0]   a_digit;
    logic [CHUNK-1:0]   nb_digit;
    logic [CHUNK-1:0]   gen;
    logic [CHUNK-1:0]   prop;
    logic [CHUNK-1:0]   sum;
    logic [CHUNK:0]     carry;
    logic               carry_term;
    logic               prop_term;

    assign accept     = can_accept & bus.in_valid;
    assign last_digit = (idx == IDX_W'(NCHUNK - 1));

    // State register; reset aborts any operation in flight
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state and handshake outputs
    always_comb begin
        next_state   = state;
        can_accept   = 1'b0;
        result_valid = 1'b0;
        unique case (state)
            IDLE: begin
                can_accept = 1'b1;
                if (bus.in_valid) next_state = RUN;
            end
            RUN: begin
                if (last_digit) next_state = DONE;
            end
            DONE: begin
                result_valid = 1'b1;
                if (bus.out_ready) next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // Current digit: a + ~b + ~borrow with lookahead carries expanded from generate/propagate
    always_comb begin
        a_digit    = a_reg[int'(idx) * CHUNK +: CHUNK];
        nb_digit   = ~b_reg[int'(idx) * CHUNK +: CHUNK];
        gen        = a_digit & nb_digit;
        prop       = a_digit ^ nb_digit;
        carry      = '0;
        carry_term = 1'b0;
        prop_term  = 1'b0;
        carry[0]   = ~borrow_reg;
        for (int i = 0; i < CHUNK; i++) begin
            carry_term = gen[i];
            prop_term  = prop[i];
            for (int j = i - 1; j >= 0; j--) begin
                carry_term = carry_term | (prop_term & gen[j]);
                prop_term  = prop_term & prop[j];
            end
            carry[i+1] = carry_term | (prop_term & carry[0]);
        end
        sum = prop ^ carry[CHUNK-1:0];
    end

    // Operand capture on accept, then one digit written per RUN cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            a_reg      <= '0;
            b_reg      <= '0;
            diff_reg   <= '0;
            borrow_reg <= 1'b0;
            bout_reg   <= 1'b0;
            idx        <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        a_reg      <= bus.a;
                        b_reg      <= bus.b;
                        borrow_reg <= bus.bin;
                        idx        <= '0;
                    end
                end
                RUN: begin
                    diff_reg[int'(idx) * CHUNK +: CHUNK] <= sum;
                    borrow_reg <= ~carry[CHUNK];
                    if (last_digit) begin
                        idx      <= '0;
                        bout_reg <= ~carry[CHUNK];
                    end else begin
                        idx <= idx + IDX_W'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

`ifdef SUB_OVERFLOW_EN
    logic ovf_reg;

    // Signed overflow: operand signs differ and the result sign departs from the minuend
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_reg <= 1'b0;
        end else if ((state == RUN) && last_digit) begin
            ovf_reg <= (a_reg[MSB] != b_reg[MSB]) & (sum[CHUNK-1] != a_reg[MSB]);
        end
    end

    assign bus.ovf = ovf_reg;
`else
    // No overflow flag in this build
`endif

    assign bus.in_ready  = can_accept;
    assign bus.out_valid = result_valid;
    assign bus.diff      = diff_reg;
    assign bus.bout      = bout_reg;
endmodule

// File: tb/tb_chunked_subtractor_seq.sv
// Testbench for chunked_subtractor_seq: directed cases on WIDTH=16/CHUNK=4,
// random traffic on WIDTH=8/CHUNK=4 and WIDTH=32/CHUNK=8, all watched by one
// negedge compare process against an arithmetic model.
module tb_chunked_subtractor_seq;
    logic clk;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    logic mon_en = 1'b0;
    logic done8  = 1'b0;
    logic done32 = 1'b0;

    chunked_subtractor_seq_if #(.WIDTH(16)) if16 ();
    chunked_subtractor_seq_if #(.WIDTH(8))  if8  ();
    chunked_subtractor_seq_if #(.WIDTH(32)) if32 ();

    chunked_subtractor_seq #(.WIDTH(16), .CHUNK(4)) u16 (.clk(clk), .rst(rst), .bus(if16));
    chunked_subtractor_seq #(.WIDTH(8),  .CHUNK(4)) u8  (.clk(clk), .rst(rst), .bus(if8));
    chunked_subtractor_seq #(.WIDTH(32), .CHUNK(8)) u32 (.clk(clk), .rst(rst), .bus(if32));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Model state per instance: 0 = 16/4, 1 = 8/4, 2 = 32/8
    int          w_of   [3] = '{16, 8, 32};
    int          nch_of [3] = '{4, 2, 4};
    logic        pend   [3];
    int          edges  [3];
    logic [31:0] exp_diff [3];
    logic        exp_bout [3];
    logic        exp_ovf  [3];

    task automatic check(input string name, input int inst, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("[TB] FAIL %s inst=%0d got=%h want=%h t=%0t", name, inst, act, want, $time);
        end
    endtask

    // Arithmetic reference: result of a - b - bin at width w, and signed overflow
    task automatic model_result(input int i, input logic [31:0] av, input logic [31:0] bv, input logic bi);
        logic [32:0] full;
        logic [31:0] mask;
        longint      sa, sb, res, lim;
        int          w;
        w    = w_of[i];
        mask = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
        full = {1'b0, av} - {1'b0, bv} - {32'd0, bi};
        exp_diff[i] = full[31:0] & mask;
        exp_bout[i] = full[32];
        lim = longint'(1) << (w - 1);
        sa  = av[w-1] ? longint'(av) - (longint'(1) << w) : longint'(av);
        sb  = bv[w-1] ? longint'(bv) - (longint'(1) << w) : longint'(bv);
        res = sa - sb - longint'(bi);
        exp_ovf[i] = (res < -lim) || (res >= lim);
    endtask

    task automatic model_step(input int i, input logic rs, input logic iv, input logic ir,
                              input logic ov, input logic orr, input logic [31:0] av,
                              input logic [31:0] bv, input logic bi, input logic [31:0] dv,
                              input logic bo, input logic of);
        logic exp_ov;
        if (pend[i]) edges[i]++;
        exp_ov = pend[i] && (edges[i] >= nch_of[i]);
        check("in_ready", i, {31'd0, ir}, {31'd0, !pend[i]});
        check("out_valid", i, {31'd0, ov}, {31'd0, exp_ov});
        if (exp_ov) begin
            check("diff", i, dv, exp_diff[i]);
            check("bout", i, {31'd0, bo}, {31'd0, exp_bout[i]});
`ifdef SUB_OVERFLOW_EN
            check("ovf", i, {31'd0, of}, {31'd0, exp_ovf[i]});
`endif
        end
        if (rs) begin
            pend[i] = 1'b0;
        end else if (exp_ov && orr) begin
            pend[i] = 1'b0;
        end else if (!pend[i] && iv) begin
            model_result(i, av, bv, bi);
            pend[i]  = 1'b1;
            edges[i] = -1;
        end
    endtask

    // Single compare process, sampling between rising edges
    always @(negedge clk) begin
        if (mon_en) begin
`ifdef SUB_OVERFLOW_EN
            model_step(0, rst, if16.in_valid, if16.in_ready, if16.out_valid, if16.out_ready,
                       32'(if16.a), 32'(if16.b), if16.bin, 32'(if16.diff), if16.bout, if16.ovf);
            model_step(1, rst, if8.in_valid, if8.in_ready, if8.out_valid, if8.out_ready,
                       32'(if8.a), 32'(if8.b), if8.bin, 32'(if8.diff), if8.bout, if8.ovf);
            model_step(2, rst, if32.in_valid, if32.in_ready, if32.out_valid, if32.out_ready,
                       if32.a, if32.b, if32.bin, if32.diff, if32.bout, if32.ovf);
`else
            model_step(0, rst, if16.in_valid, if16.in_ready, if16.out_valid, if16.out_ready,
                       32'(if16.a), 32'(if16.b), if16.bin, 32'(if16.diff), if16.bout, 1'b0);
            model_step(1, rst, if8.in_valid, if8.in_ready, if8.out_valid, if8.out_ready,
                       32'(if8.a), 32'(if8.b), if8.bin, 32'(if8.diff), if8.bout, 1'b0);
            model_step(2, rst, if32.in_valid, if32.in_ready, if32.out_valid, if32.out_ready,
                       if32.a, if32.b, if32.bin, if32.diff, if32.bout, 1'b0);
`endif
        end
    end

    // Directed operation on the 16-bit instance; hold_cycles keeps out_ready low after out_valid
    task automatic applyStimulus(input logic [15:0] av, input logic [15:0] bv, input logic bi,
                                 input int hold_cycles, output logic [15:0] got_diff,
                                 output logic got_bout, output logic got_ovf, output int latency);
        int budget;
        @(posedge clk); #1;
        if16.in_valid = 1'b1;
        if16.a = av;
        if16.b = bv;
        if16.bin = bi;
        budget = 0;
        forever begin
            @(negedge clk);
            if (if16.in_ready) break;
            budget++;
            if (budget > 50) begin
                check("accept_timeout", 0, 32'(budget), 32'd0);
                break;
            end
        end
        @(posedge clk); #1;
        if16.in_valid = 1'b0;
        latency = 0;
        forever begin
            @(negedge clk);
            if (if16.out_valid) break;
            latency++;
            if (latency > 50) begin
                check("result_timeout", 0, 32'(latency), 32'd4);
                break;
            end
        end
        got_diff = if16.diff;
        got_bout = if16.bout;
`ifdef SUB_OVERFLOW_EN
        got_ovf = if16.ovf;
`else
        got_ovf = 1'b0;
`endif
        @(posedge clk); #1;
        for (int k = 0; k < hold_cycles; k++) begin
            @(negedge clk);
            check("hold_out_valid", 0, {31'd0, if16.out_valid}, 32'd1);
            check("hold_in_ready", 0, {31'd0, if16.in_ready}, 32'd0);
            check("hold_diff", 0, 32'(if16.diff), 32'(got_diff));
            @(posedge clk); #1;
        end
        if16.out_ready = 1'b1;
        @(posedge clk); #1;
        if16.out_ready = 1'b0;
    endtask

    task automatic checkOutput(input string tag, input logic [15:0] got_diff, input logic got_bout,
                               input logic got_ovf, input int latency, input logic [15:0] want_diff,
                               input logic want_bout, input logic want_ovf);
        check({tag, "_diff"}, 0, 32'(got_diff), 32'(want_diff));
        check({tag, "_bout"}, 0, {31'd0, got_bout}, {31'd0, want_bout});
        check({tag, "_latency"}, 0, 32'(latency), 32'd4);
`ifdef SUB_OVERFLOW_EN
        check({tag, "_ovf"}, 0, {31'd0, got_ovf}, {31'd0, want_ovf});
`endif
    endtask

    task automatic run8(input int nops);
        int budget;
        for (int n = 0; n < nops; n++) begin
            repeat ($urandom_range(0, 1)) begin
                @(posedge clk); #1;
                if8.in_valid = 1'b0;
                if8.a = 8'($urandom);
                if8.b = 8'($urandom);
            end
            @(posedge clk); #1;
            if8.in_valid = 1'b1;
            if8.a   = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
            if8.b   = ($urandom_range(0, 7) == 0) ? 8'hFF : 8'($urandom);
            if8.bin = 1'($urandom);
            budget = 0;
            forever begin
                @(negedge clk);
                if (if8.in_valid && if8.in_ready) break;
                budget++;
                if (budget > 200) begin
                    check("accept_timeout", 1, 32'(budget), 32'd0);
                    break;
                end
                @(posedge clk); #1;
                if ($urandom_range(0, 3) == 0) begin
                    if8.in_valid = 1'b0;
                    if8.a = 8'($urandom);
                    if8.b = 8'($urandom);
                end else begin
                    if8.in_valid = 1'b1;
                end
            end
            @(posedge clk); #1;
            if8.in_valid = 1'b0;
        end
    endtask

    task automatic run32(input int nops);
        int budget;
        for (int n = 0; n < nops; n++) begin
            repeat ($urandom_range(0, 1)) begin
                @(posedge clk); #1;
                if32.in_valid = 1'b0;
                if32.a = $urandom;
                if32.b = $urandom;
            end
            @(posedge clk); #1;
            if32.in_valid = 1'b1;
            if32.a   = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom;
            if32.b   = ($urandom_range(0, 7) == 0) ? 32'h0000_0001 : $urandom;
            if32.bin = 1'($urandom);
            budget = 0;
            forever begin
                @(negedge clk);
                if (if32.in_valid && if32.in_ready) break;
                budget++;
                if (budget > 200) begin
                    check("accept_timeout", 2, 32'(budget), 32'd0);
                    break;
                end
                @(posedge clk); #1;
                if ($urandom_range(0, 3) == 0) begin
                    if32.in_valid = 1'b0;
                    if32.a = $urandom;
                    if32.b = $urandom;
                end else begin
                    if32.in_valid = 1'b1;
                end
            end
            @(posedge clk); #1;
            if32.in_valid = 1'b0;
        end
    endtask

    initial begin
        #950000;
        errors++;
        $display("[TB] FAIL global_timeout t=%0t", $time);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        logic [15:0] d;
        logic        bo;
        logic        of;
        int          lat;

        for (int i = 0; i < 3; i++) begin
            pend[i]  = 1'b0;
            edges[i] = 0;
        end
        rst = 1'b1;
        if16.in_valid = 1'b0; if16.a = '0; if16.b = '0; if16.bin = 1'b0; if16.out_ready = 1'b0;
        if8.in_valid  = 1'b0; if8.a  = '0; if8.b  = '0; if8.bin  = 1'b0; if8.out_ready  = 1'b0;
        if32.in_valid = 1'b0; if32.a = '0; if32.b = '0; if32.bin = 1'b0; if32.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        mon_en = 1'b1;

        @(negedge clk);
        check("reset_in_ready", 0, {31'd0, if16.in_ready}, 32'd1);
        check("reset_out_valid", 0, {31'd0, if16.out_valid}, 32'd0);
        check("reset_diff", 0, 32'(if16.diff), 32'd0);
        check("reset_bout", 0, {31'd0, if16.bout}, 32'd0);
`ifdef SUB_OVERFLOW_EN
        check("reset_ovf", 0, {31'd0, if16.ovf}, 32'd0);
`endif

        applyStimulus(16'h1234, 16'h0234, 1'b0, 0, d, bo, of, lat);
        checkOutput("basic", d, bo, of, lat, 16'h1000, 1'b0, 1'b0);
        applyStimulus(16'h0000, 16'h0001, 1'b0, 0, d, bo, of, lat);
        checkOutput("ripple", d, bo, of, lat, 16'hFFFF, 1'b1, 1'b0);
        applyStimulus(16'h8000, 16'h0001, 1'b0, 0, d, bo, of, lat);
        checkOutput("ovf_case", d, bo, of, lat, 16'h7FFF, 1'b0, 1'b1);
        applyStimulus(16'h0005, 16'h0005, 1'b1, 0, d, bo, of, lat);
        checkOutput("bin_case", d, bo, of, lat, 16'hFFFF, 1'b1, 1'b0);
        applyStimulus(16'h0005, 16'h0005, 1'b1, 10, d, bo, of, lat);
        checkOutput("backpressure", d, bo, of, lat, 16'hFFFF, 1'b1, 1'b0);

        // Abort: reset lands in the second RUN cycle
        @(posedge clk); #1;
        if16.in_valid = 1'b1;
        if16.a = 16'h1111;
        if16.b = 16'h2222;
        if16.bin = 1'b0;
        @(negedge clk);
        check("abort_accept_ready", 0, {31'd0, if16.in_ready}, 32'd1);
        @(posedge clk); #1;
        if16.in_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("abort_in_ready", 0, {31'd0, if16.in_ready}, 32'd1);
        for (int k = 0; k < 6; k++) begin
            check("abort_out_valid", 0, {31'd0, if16.out_valid}, 32'd0);
            @(negedge clk);
        end
        applyStimulus(16'h00FF, 16'h000F, 1'b0, 0, d, bo, of, lat);
        checkOutput("after_abort", d, bo, of, lat, 16'h00F0, 1'b0, 1'b0);

        $display("[TB] directed phase complete, starting random traffic");
        fork
            begin
                run8(5000);
                done8 = 1'b1;
            end
            begin
                run32(5000);
                done32 = 1'b1;
            end
            begin
                while (!(done8 && done32)) begin
                    @(posedge clk); #1;
                    if8.out_ready  = ($urandom_range(0, 2) != 0);
                    if32.out_ready = ($urandom_range(0, 3) != 0);
                end
            end
        join
        if8.out_ready  = 1'b1;
        if32.out_ready = 1'b1;
        repeat (12) @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            check("drained", i, {31'd0, pend[i]}, 32'd0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
